// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types and the bitwise op helper for the logic unit arbiter.
// Opcode and FSM encodings live here so every file agrees on them.
package logic_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  // Single-bit slice of the logic unit; applied per bit so any width works.
  function automatic logic logic_bit(
    logic_op_e op,
    logic      a,
    logic      b
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the requesters and the arbiter.
// Requester i uses bit i of each vector and slice i of the packed buses.
interface logic_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*2-1:0] req_op;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [W-1:0]       rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// N-way round-robin one-hot grant: first request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit between N_REQ requesters with
// round-robin grant, one registered compute cycle and a held response.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  logic_unit_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int PW = $clog2(N_REQ);

  arb_state_e       state, state_nx;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    gnt_idx;
  logic [N_REQ-1:0] grant;
  logic [W-1:0]     a_q, b_q;
  logic_op_e        op_q;
  logic [W-1:0]     result;
  logic [W-1:0]     data_q;
  logic             take, done;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign result[i] = logic_bit(op_q, a_q[i], b_q[i]);
  end

  assign take = (state == IDLE) && (|grant);
  assign done = (state == RESP) && bus.rsp_ready[winner];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is gated by rst so nothing looks accepted while held in reset.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (state == IDLE && !rst) bus.req_ready = grant;
    if (state == RESP) bus.rsp_valid = N_REQ'(1) << winner;
  end

  assign busy         = (state != IDLE);
  assign bus.rsp_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      winner <= '0;
    end else if (take) begin
      a_q    <= bus.req_a[int'(gnt_idx)*W +: W];
      b_q    <= bus.req_b[int'(gnt_idx)*W +: W];
      op_q   <= logic_op_e'(bus.req_op[int'(gnt_idx)*2 +: 2]);
      winner <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (state == EXEC) begin
      data_q <= result;
    end
  end

  // Pointer only advances on completion, so a stalled winner keeps priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      ops_done <= '0;
    end else if (done) begin
      rr_ptr <= (winner == PW'(N_REQ-1)) ? '0 : winner + PW'(1);
      if (ops_done != {CNT_W{1'b1}}) ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter against a
// transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [CW-1:0] ops_done;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  logic_unit_arbiter #(.N_REQ(N), .W(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .ops_done (ops_done)
  );

  int n_chk = 0;
  int n_bad = 0;

  bit         hold [N];
  logic [7:0] ha   [N];
  logic [7:0] hb   [N];
  logic [1:0] hop  [N];

  bit         inflight = 0;
  int         owner    = 0;
  int         ptr      = 0;
  int         count    = 0;
  int         hs_cyc   = 0;
  int         cyc      = 0;
  logic [7:0] res      = '0;
  logic [7:0] last_rsp = '0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] calc(logic [1:0] op, logic [7:0] a,
                                      logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int sat(int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic issue(int i, logic [7:0] a, logic [7:0] b, logic [1:0] op);
    hold[i] = 1;
    ha[i]   = a;
    hb[i]   = b;
    hop[i]  = op;
  endtask

  task automatic model_step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    int           g;
    exp_rdy = '0;
    exp_rv  = '0;
    g       = -1;
    if (!inflight) begin
      g = pick(bus.req_valid, ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end else if (cyc - hs_cyc >= 2) begin
      exp_rv[owner] = 1'b1;
    end
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(inflight));
    check("ops_done", 32'(ops_done), 32'(sat(count)));
    if (exp_rv != '0) check("rsp_data", 32'(bus.rsp_data), 32'(res));
    if (g >= 0) begin
      inflight = 1;
      owner    = g;
      res      = calc(hop[g], ha[g], hb[g]);
      hs_cyc   = cyc;
      hold[g]  = 0;
    end else if (inflight && (cyc - hs_cyc >= 2) && bus.rsp_ready[owner]) begin
      inflight = 0;
      ptr      = (owner + 1) % N;
      count++;
      last_rsp = bus.rsp_data;
    end
    cyc++;
  endtask

  task automatic run(int n, int spawn_pct, int rdy_pct, int wd_pct);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && ($urandom % 100) < spawn_pct) begin
          issue(i, 8'($urandom), 8'($urandom), 2'($urandom));
        end else if (hold[i] && !inflight && ($urandom % 100) < wd_pct) begin
          hold[i] = 0;
        end
        bus.req_valid[i]       = hold[i];
        bus.req_a[i*W +: W]    = hold[i] ? ha[i] : 8'($urandom);
        bus.req_b[i*W +: W]    = hold[i] ? hb[i] : 8'($urandom);
        bus.req_op[i*2 +: 2]   = hold[i] ? hop[i] : 2'($urandom);
        bus.rsp_ready[i]       = (($urandom % 100) < rdy_pct);
      end
      #1;
      model_step();
    end
  endtask

  logic [7:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 8'h05;
    sweep_exp[1] = 8'hAF;
    sweep_exp[2] = 8'hAA;
    sweep_exp[3] = 8'hFA;
    for (int i = 0; i < N; i++) hold[i] = 0;

    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ops_done", 32'(ops_done), 32'(0));
    check("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    issue(0, 8'hF0, 8'h3C, 2'd0);
    run(4, 0, 100, 0);
    check("single_data", 32'(last_rsp), 32'h30);
    check("single_ops", 32'(ops_done), 32'(1));

    for (int op = 0; op < 4; op++) begin
      issue(2, 8'hA5, 8'h0F, 2'(op));
      run(3, 0, 100, 0);
      check("sweep_data", 32'(last_rsp), 32'(sweep_exp[op]));
    end

    run(24, 100, 100, 0);
    run(12, 0, 100, 0);

    issue(1, 8'h5A, 8'hC3, 2'd2);
    run(2, 0, 100, 0);
    issue(0, 8'h11, 8'h22, 2'd1);
    issue(3, 8'h33, 8'h44, 2'd3);
    run(5, 0, 0, 0);
    run(1, 0, 100, 0);
    check("bp_data", 32'(last_rsp), 32'(8'h99));
    run(12, 0, 100, 0);

    issue(1, 8'hFF, 8'h0F, 2'd0);
    run(1, 0, 0, 0);
    issue(3, 8'h0C, 8'h0A, 2'd2);
    run(2, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_ops_done", 32'(ops_done), 32'(0));
    check("arst_rsp_data", 32'(bus.rsp_data), 32'(0));
    check("arst_req_ready", 32'(bus.req_ready), 32'(0));
    inflight = 0;
    ptr      = 0;
    count    = 0;
    hold[1]  = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    run(4, 0, 100, 0);
    check("post_rst_data", 32'(last_rsp), 32'(8'h06));
    check("post_rst_ops", 32'(ops_done), 32'(1));

    run(600, 30, 60, 5);
    check("sat_ops", 32'(ops_done), 32'(sat(count)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
